// File: rtl/sysid_info_slave.sv
// System-ID / build-info Avalon-MM slave with uptime counter, scratch and control.
// Fixed read latency of one cycle, no waitrequest.
module sysid_info_slave #(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'd0,
    parameter logic [7:0]  VER_MAJOR     = 8'd1,
    parameter logic [7:0]  VER_MINOR     = 8'd0,
    parameter logic [15:0] VER_PATCH     = 16'd0,
    parameter logic [31:0] CLK_FREQ_HZ   = 32'd50000000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] A_ID    = 3'd0;
    localparam logic [2:0] A_TS    = 3'd1;
    localparam logic [2:0] A_VER   = 3'd2;
    localparam logic [2:0] A_FREQ  = 3'd3;
    localparam logic [2:0] A_UPLO  = 3'd4;
    localparam logic [2:0] A_UPHI  = 3'd5;
    localparam logic [2:0] A_SCR   = 3'd6;
    localparam logic [2:0] A_CTRL  = 3'd7;

    logic [63:0] uptime_q,   uptime_d;
    logic [31:0] hi_snap_q,  hi_snap_d;
    logic [31:0] scratch_q,  scratch_d;
    logic        freeze_q,   freeze_d;
    logic [31:0] readdata_q, readdata_d;
    logic        rdv_q,      rdv_d;

    logic        wr_en;
    logic        ctrl_wr;
    logic        clear;
    logic [31:0] rd_mux;

    // A simultaneous read wins; the write is dropped entirely.
    always_comb begin
        wr_en   = write & ~read;
        ctrl_wr = wr_en && (address == A_CTRL) && byteenable[0];
        clear   = ctrl_wr & writedata[0];
        freeze_d = ctrl_wr ? writedata[1] : freeze_q;

        if (clear)
            uptime_d = '0;
        else if (freeze_q)
            uptime_d = uptime_q;
        else
            uptime_d = uptime_q + 64'd1;

        scratch_d = scratch_q;
        if (wr_en && (address == A_SCR)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b])
                    scratch_d[b*8 +: 8] = writedata[b*8 +: 8];
            end
        end

        rd_mux = '0;
        case (address)
            A_ID:    rd_mux = SYSTEM_ID;
            A_TS:    rd_mux = TIMESTAMP;
            A_VER:   rd_mux = {VER_MAJOR, VER_MINOR, VER_PATCH};
            A_FREQ:  rd_mux = CLK_FREQ_HZ;
            A_UPLO:  rd_mux = uptime_q[31:0];
            A_UPHI:  rd_mux = hi_snap_q;
            A_SCR:   rd_mux = scratch_q;
            A_CTRL:  rd_mux = {30'd0, freeze_q, 1'b0};
            default: rd_mux = '0;
        endcase

        // LO read latches the matching HI half for an atomic 64-bit view.
        hi_snap_d = (read && (address == A_UPLO)) ? uptime_q[63:32] : hi_snap_q;

        readdata_d = read ? rd_mux : readdata_q;
        rdv_d      = read;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime_q   <= '0;
            hi_snap_q  <= '0;
            scratch_q  <= SCRATCH_RESET;
            freeze_q   <= 1'b0;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
        end else begin
            uptime_q   <= uptime_d;
            hi_snap_q  <= hi_snap_d;
            scratch_q  <= scratch_d;
            freeze_q   <= freeze_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule
